matmul_seq: RTL
===============

Name: matmul_seq

Overview:
- Parametrised, sequential N×N matrix multiplier computing C = A·B with one shared multiply-accumulate unit.
- Operands stream in over a valid/ready input port and results stream out over a valid/ready output port.
- Replaces the fixed 2×2 fully-combinational multiplier in datapaths where area matters more than latency.
- Result width is full precision, so no overflow or truncation is possible.

Parameters:
- N, 2, matrix dimension (N ≥ 2).
- W, 4, operand entry width in bits.
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and result.
- OW, 2*W+$clog2(N), result entry width. Derived; not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_a/in_b carry a valid operand pair.
- in_ready  output  1  block accepts an operand pair this cycle.
- in_a  input  W  entry of A, row-major order.
- in_b  input  W  entry of B, row-major order.
- out_valid  output  1  out_c holds a valid result entry.
- out_ready  input  1  downstream accepts out_c this cycle.
- out_c  output  OW  entry of C, row-major order.
- out_last  output  1  marks C[N-1][N-1]; qualified by out_valid.
- busy  output  1  high in COMPUTE or OUTPUT.

Behaviour:
- Reset (sync, active-high), applied from any state at any time:
  - State goes to LOAD; all index counters and the accumulator clear.
  - Outputs: in_ready=1, out_valid=0, out_last=0, busy=0, out_c=0.
  - Stored A/B/C contents are don't-care.
  - Reset mid-operation discards the transaction; nothing partial is ever output.
- Handshake: a transfer occurs when valid && ready are both high on a rising edge.
  - Senders hold data stable while valid=1 and ready=0.
  - Valid never depends combinationally on ready.
- LOAD:
  - in_ready=1, out_valid=0.
  - Each input handshake writes A[i][j]=in_a and B[i][j]=in_b at load index k (i=k/N, j=k%N), then increments k.
  - Gaps in in_valid are allowed.
  - On the handshake with k=N*N-1, go to COMPUTE next cycle.
- COMPUTE:
  - in_ready=0, busy=1.
  - One MAC per cycle: acc += A[r][m]*B[m][c], with m stepping 0..N-1.
  - At m=N-1, write C[r][c] = final sum, clear acc, advance c then r.
  - Exactly N³ cycles. The cycle after the last MAC enters OUTPUT.
- OUTPUT:
  - out_valid=1; out_c=C[p/N][p%N] for output index p.
  - out_last=1 exactly when p=N*N-1.
  - Each output handshake increments p.
  - Handshake with out_last=1 returns to LOAD next cycle, with in_ready=1 that cycle.
  - No overlap between load and output.
- Latency: last input handshake at cycle t gives out_valid first high at cycle t+N³+1. Best-case throughput is one matrix per N²+N³+N² cycles.
- Arithmetic:
  - SIGNED=0: zero-extend operands; product is 2W bits; accumulate in OW bits.
  - SIGNED=1: sign-extend operands and products to OW.
  - OW is full precision for both modes; no saturation or wrap required.
- Backpressure: out_ready=0 holds out_c, out_last and p unchanged indefinitely.
- in_valid asserted outside LOAD is ignored (in_ready=0), and no operand is consumed.

Test Plan:
- Basic, N=2, W=4, SIGNED=0: A={1,2,3,4}, B={5,6,7,8} loaded back-to-back → out_c sequence 19, 22, 43, 50; out_last only on 50; first out_valid exactly 9 cycles after the last input handshake.
- Max values, unsigned: all entries 15 → four outputs of 450 (9-bit, no truncation); repeat with out_ready toggling every other cycle → same values in order, each held stable while stalled.
- Signed, SIGNED=1: A={-8,-8,7,-1}, B={-8,7,-8,7} → C={128,-112,-48,42}.
- Reset mid-operation: assert reset for 1 cycle during COMPUTE, then load identity A={1,0,0,1} and B={9,3,2,5} → output 9, 3, 2, 5; no stale outputs; in_ready=1 the cycle after reset.
- Input gaps and ignore: in_valid low for 3 cycles between beats → same result as back-to-back; in_valid held high during COMPUTE/OUTPUT → no extra beats consumed, next matrix loads correctly after out_last.
- Scaling, N=3, W=8, SIGNED=0: A=all 255, B=all 255 → nine outputs of 195075 (OW=18); COMPUTE lasts exactly 27 cycles.

Source files
------------

// File: rtl/matmul_seq.sv
// Sequential NxN matrix multiplier C = A*B built around one shared multiply-accumulate unit.
// Operands stream in row-major over valid/ready; results stream out row-major over valid/ready.
module matmul_seq #(
    parameter int unsigned N      = 2,
    parameter int unsigned W      = 4,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned OW     = 2 * W + $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_c,
    output logic          out_last,
    output logic          busy
);

    localparam int unsigned NN = N * N;
    localparam int unsigned KW = $clog2(NN);
    localparam int unsigned IW = $clog2(N);
    localparam logic [KW-1:0] KLast = KW'(NN - 1);
    localparam logic [IW-1:0] ILast = IW'(N - 1);

    typedef enum logic [1:0] {StLoad, StCompute, StOutput} state_e;

    state_e state_q, state_d;

    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] p_q, p_d;
    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;
    logic [IW-1:0] m_q, m_d;
    logic [OW-1:0] acc_q, acc_d;

    logic [W-1:0]  a_q [NN];
    logic [W-1:0]  a_d [NN];
    logic [W-1:0]  b_q [NN];
    logic [W-1:0]  b_d [NN];
    logic [OW-1:0] c_mem_q [NN];
    logic [OW-1:0] c_mem_d [NN];

    logic [KW-1:0] a_addr, b_addr, c_addr;
    logic [W-1:0]  op_a, op_b;
    logic          fill_a, fill_b;
    logic [OW-1:0] ext_a, ext_b;
    logic [OW-1:0] prod;
    logic [OW-1:0] mac_sum;
    logic          mac_last;

    // MAC operand addressing: A[row][m] and B[m][col], result slot C[row][col].
    always_comb begin
        a_addr = KW'(32'(row_q) * N + 32'(m_q));
        b_addr = KW'(32'(m_q) * N + 32'(col_q));
        c_addr = KW'(32'(row_q) * N + 32'(col_q));
    end

    // Extending to OW before multiplying keeps the product exact in both modes,
    // since the true signed/unsigned result always fits in OW bits.
    always_comb begin
        op_a    = a_q[a_addr];
        op_b    = b_q[b_addr];
        fill_a  = (SIGNED != 0) && op_a[W-1];
        fill_b  = (SIGNED != 0) && op_b[W-1];
        ext_a   = {{(OW - W){fill_a}}, op_a};
        ext_b   = {{(OW - W){fill_b}}, op_b};
        prod    = ext_a * ext_b;
        mac_sum = acc_q + prod;
    end

    assign mac_last = (row_q == ILast) && (col_q == ILast) && (m_q == ILast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad: begin
                if (in_valid && (k_q == KLast)) begin
                    state_d = StCompute;
                end
            end
            StCompute: begin
                if (mac_last) begin
                    state_d = StOutput;
                end
            end
            StOutput: begin
                if (out_ready && (p_q == KLast)) begin
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_c     = '0;
        unique case (state_q)
            StLoad: begin
                in_ready = 1'b1;
            end
            StCompute: begin
                busy = 1'b1;
            end
            StOutput: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_c     = c_mem_q[p_q];
                out_last  = (p_q == KLast);
            end
            default: ;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        c_mem_d = c_mem_q;
        k_d     = k_q;
        p_d     = p_q;
        row_d   = row_q;
        col_d   = col_q;
        m_d     = m_q;
        acc_d   = acc_q;
        unique case (state_q)
            StLoad: begin
                if (in_valid) begin
                    a_d[k_q] = in_a;
                    b_d[k_q] = in_b;
                    k_d      = (k_q == KLast) ? '0 : k_q + KW'(1);
                end
            end
            StCompute: begin
                if (m_q == ILast) begin
                    c_mem_d[c_addr] = mac_sum;
                    acc_d           = '0;
                    m_d             = '0;
                    if (col_q == ILast) begin
                        col_d = '0;
                        row_d = (row_q == ILast) ? '0 : row_q + IW'(1);
                    end else begin
                        col_d = col_q + IW'(1);
                    end
                end else begin
                    acc_d = mac_sum;
                    m_d   = m_q + IW'(1);
                end
            end
            StOutput: begin
                if (out_ready) begin
                    p_d = (p_q == KLast) ? '0 : p_q + KW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q   <= '0;
            p_q   <= '0;
            row_q <= '0;
            col_q <= '0;
            m_q   <= '0;
            acc_q <= '0;
        end else begin
            k_q   <= k_d;
            p_q   <= p_d;
            row_q <= row_d;
            col_q <= col_d;
            m_q   <= m_d;
            acc_q <= acc_d;
        end
    end

    // Matrix storage carries no reset: contents are rewritten before every use.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        c_mem_q <= c_mem_d;
    end

endmodule
